// File: rtl/serial_half_subtractor.sv
// Bit-serial handshaked half subtractor: one lane per clock, LSB first.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + a/b operands,
//   out_valid/out_ready + diff/borrow results, busy (SHIFT or DONE).
// Build option: define HALF_SUB_BORROW_CHAIN_EN to ripple the borrow
//   between lanes, turning the block into a serial full subtractor.
module serial_half_subtractor #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] lane_sel;
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] borrow_d;
  logic             last;

`ifdef HALF_SUB_BORROW_CHAIN_EN
  logic bin_q;
`endif

  always_comb begin
    lane_sel = WIDTH'(1) << cnt_q;
`ifdef HALF_SUB_BORROW_CHAIN_EN
    d_bit  = a_q[0] ^ b_q[0] ^ bin_q;
    bo_bit = (~a_q[0] & b_q[0])
           | (~(a_q[0] ^ b_q[0]) & bin_q);
`else
    d_bit  = a_q[0] ^ b_q[0];
    bo_bit = ~a_q[0] & b_q[0];
`endif
    // Result regs are cleared on accept, so OR-ing in one lane is enough.
    diff_d   = diff_q | ({WIDTH{d_bit}} & lane_sel);
    borrow_d = borrow_q | ({WIDTH{bo_bit}} & lane_sel);
    last     = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef HALF_SUB_BORROW_CHAIN_EN
      bin_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= SHIFT;
            a_q        <= a;
            b_q        <= b;
            diff_q     <= '0;
            borrow_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef HALF_SUB_BORROW_CHAIN_EN
            bin_q      <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
`ifdef HALF_SUB_BORROW_CHAIN_EN
          bin_q    <= bo_bit;
`endif
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_half_subtractor.sv
// Directed bench for serial_half_subtractor (WIDTH=4).
// Expected values follow the build option HALF_SUB_BORROW_CHAIN_EN.
module tb_serial_half_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic [W-1:0] borrow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic [W-1:0] bo;
  } vec_t;

  vec_t vt[6];

  serial_half_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] va,
                        input logic [W-1:0] vb,
                        input logic [W-1:0] ed,
                        input logic [W-1:0] eb);
    int n;
    chk("idle_ready", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operand changes after the accept must not matter.
    a = ~va;
    b = ~vb;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("diff", 32'(diff), 32'(ed));
    chk("borrow", 32'(borrow), 32'(eb));
    chk("done_busy", 32'({busy, in_ready}), 32'b10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_idle",
        32'({out_valid, in_ready, busy}), 32'b010);
    chk("held_diff", 32'({diff, borrow}), 32'({ed, eb}));
  endtask

  initial begin
`ifdef HALF_SUB_BORROW_CHAIN_EN
    vt[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    vt[1] = '{4'b0000, 4'b0001, 4'b1111, 4'b1111};
    vt[2] = '{4'b0101, 4'b0011, 4'b0010, 4'b0010};
    vt[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
    vt[4] = '{4'b1010, 4'b0101, 4'b0101, 4'b0101};
    vt[5] = '{4'b1000, 4'b0001, 4'b0111, 4'b0111};
`else
    vt[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    vt[1] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
    vt[2] = '{4'b0101, 4'b0011, 4'b0110, 4'b0010};
    vt[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
    vt[4] = '{4'b1010, 4'b0101, 4'b1111, 4'b0101};
    vt[5] = '{4'b1000, 4'b0001, 4'b1001, 4'b0001};
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst_state",
        32'({in_ready, out_valid, busy, diff, borrow}),
        32'b100_0000_0000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_op(vt[i].a, vt[i].b, vt[i].d, vt[i].bo);

    // Backpressure: hold result 10 cycles, ignore a new offer.
    a = 4'b0101;
    b = 4'b0011;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    a = 4'b1111;
    b = 4'b0000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold",
          32'({out_valid, in_ready, diff, borrow}),
          32'({2'b10, vt[2].d, vt[2].bo}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release",
        32'({out_valid, in_ready, busy}), 32'b010);
    tick();
    chk("bp_no_accept", 32'(busy), 32'd0);

    // Reset on the 2nd SHIFT edge discards the operation.
    a = 4'b0101;
    b = 4'b0011;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst",
        32'({in_ready, out_valid, busy, diff, borrow}),
        32'b100_0000_0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_quiet", 32'({out_valid, busy}), 32'd0);
    end
    run_op(4'b0011, 4'b0001, 4'b0010, 4'b0000);

    // Reset and in_valid together: nothing accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    a = 4'b1111;
    b = 4'b0001;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_wins",
        32'({in_ready, busy, diff, borrow}),
        32'b1_0_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
